// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one registered
// hex decoder. Display values are double-buffered and only committed at frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzs_en,
  output logic [3:0]              num_out,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_start
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam int unsigned CntW = $clog2(BLANK_CYCLES);
  localparam int unsigned PreW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(BLANK_CYCLES - 1);
  localparam logic [PreW-1:0] PreMax = PreW'(REFRESH_DIV - 1);

  typedef enum logic [0:0] {StBlank, StShow} state_e;
  typedef logic [NUM_DIGITS-1:0][3:0] nibbles_t;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [PreW-1:0]       pre_q, pre_d;
  logic                  start_q;

  nibbles_t              shd_val_q, shd_val_d;
  logic [NUM_DIGITS-1:0] shd_en_q, shd_en_d;
  logic                  shd_lzs_q, shd_lzs_d;
  logic                  pending_q, pending_d;

  nibbles_t              frm_val_q, frm_val_d;
  logic [NUM_DIGITS-1:0] frm_en_q, frm_en_d;
  logic                  frm_lzs_q, frm_lzs_d;

  logic [3:0]            num_q, num_d;
  logic [NUM_DIGITS-1:0] sel_n_q, sel_n_d;
  logic                  fs_q, fs_d;

  logic                  entry;
  logic [NUM_DIGITS-1:0] supp;
  logic [NUM_DIGITS-1:0] dark;

  // A digit is suppressed while it and every digit above it hold zero; digit 0 never is.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    supp       = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (frm_val_q[i] == 4'h0);
      supp[i]    = frm_lzs_q & zero_above;
    end
  end

  assign dark = ~frm_en_q | supp;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    shd_val_d = shd_val_q;
    shd_en_d  = shd_en_q;
    shd_lzs_d = shd_lzs_q;
    pending_d = pending_q;
    frm_val_d = frm_val_q;
    frm_en_d  = frm_en_q;
    frm_lzs_d = frm_lzs_q;
    num_d     = num_q;
    sel_n_d   = sel_n_q;
    fs_d      = 1'b0;
    entry     = 1'b0;

    unique case (state_q)
      StBlank: begin
        if (start_q) begin
          // First edge out of reset acts as the idx-0 BLANK entry.
          entry = 1'b1;
        end else if (cnt_q == CntMax) begin
          state_d = StShow;
          cnt_d   = '0;
          sel_n_d = '1;
          if (!dark[idx_q]) begin
            sel_n_d[idx_q] = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShow: begin
        if (pre_q == PreMax) begin
          state_d = StBlank;
          pre_d   = '0;
          idx_d   = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
          entry   = 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
    endcase

    if (entry) begin
      sel_n_d = '1;
      if (idx_d == '0) begin
        fs_d = 1'b1;
        if (pending_q) begin
          frm_val_d = shd_val_q;
          frm_en_d  = shd_en_q;
          frm_lzs_d = shd_lzs_q;
          pending_d = 1'b0;
        end
      end
      num_d = frm_val_d[idx_d];
    end

    // A load on the commit edge lands after the commit and stays pending.
    if (load) begin
      shd_val_d = value;
      shd_en_d  = digit_en;
      shd_lzs_d = lzs_en;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StBlank;
      idx_q     <= '0;
      cnt_q     <= '0;
      pre_q     <= '0;
      start_q   <= 1'b1;
      shd_val_q <= '0;
      shd_en_q  <= '0;
      shd_lzs_q <= 1'b0;
      pending_q <= 1'b0;
      frm_val_q <= '0;
      frm_en_q  <= '0;
      frm_lzs_q <= 1'b0;
      num_q     <= 4'h0;
      sel_n_q   <= '1;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      start_q   <= 1'b0;
      shd_val_q <= shd_val_d;
      shd_en_q  <= shd_en_d;
      shd_lzs_q <= shd_lzs_d;
      pending_q <= pending_d;
      frm_val_q <= frm_val_d;
      frm_en_q  <= frm_en_d;
      frm_lzs_q <= frm_lzs_d;
      num_q     <= num_d;
      sel_n_q   <= sel_n_d;
      fs_q      <= fs_d;
    end
  end

  assign num_out     = num_q;
  assign digit_sel_n = sel_n_q;
  assign frame_start = fs_q;

  a_one_anode: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(~digit_sel_n));

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed and randomized scan sequences checked cycle-by-cycle against a frame-position model.
module tb_seven_seg_scan_ctrl;

  localparam int N    = 4;
  localparam int RD   = 8;
  localparam int BC   = 2;
  localparam int SLOT = RD + BC;
  localparam int FP   = N * SLOT;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           load;
  logic [4*N-1:0] value;
  logic [N-1:0]   digit_en;
  logic           lzs_en;
  logic [3:0]     num_out;
  logic [N-1:0]   digit_sel_n;
  logic           frame_start;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .value      (value),
    .digit_en   (digit_en),
    .lzs_en     (lzs_en),
    .num_out    (num_out),
    .digit_sel_n(digit_sel_n),
    .frame_start(frame_start)
  );

  int checks = 0;
  int passed = 0;

  // Model: position within the frame plus shadow/frame copies of the display request.
  bit             m_started;
  int             m_t;
  logic [4*N-1:0] m_shd_val, m_frm_val;
  logic [N-1:0]   m_shd_en, m_frm_en;
  logic           m_shd_lzs, m_frm_lzs;
  bit             m_pending;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_started = 0;
    m_t       = 0;
    m_shd_val = '0;
    m_frm_val = '0;
    m_shd_en  = '0;
    m_frm_en  = '0;
    m_shd_lzs = 1'b0;
    m_frm_lzs = 1'b0;
    m_pending = 0;
  endtask

  function automatic bit digit_lit(input int d);
    int top = 0;
    for (int i = 0; i < N; i++) if (m_frm_val[4*i +: 4] != 4'h0) top = i;
    if (!m_frm_en[d]) return 0;
    if (m_frm_lzs && d > top) return 0;
    return 1;
  endfunction

  task automatic cycle();
    logic [N-1:0] esel;
    int slot, ph;
    @(posedge clk);
    if (!m_started) begin
      m_started = 1;
      m_t       = 0;
    end else begin
      m_t = (m_t + 1) % FP;
    end
    if (m_t == 0 && m_pending) begin
      m_frm_val = m_shd_val;
      m_frm_en  = m_shd_en;
      m_frm_lzs = m_shd_lzs;
      m_pending = 0;
    end
    if (load) begin
      m_shd_val = value;
      m_shd_en  = digit_en;
      m_shd_lzs = lzs_en;
      m_pending = 1;
    end
    @(negedge clk);
    slot = m_t / SLOT;
    ph   = m_t % SLOT;
    esel = '1;
    if (ph >= BC && digit_lit(slot)) esel[slot] = 1'b0;
    check("digit_sel_n", digit_sel_n, esel);
    check("num_out", num_out, m_frm_val[4*slot +: 4]);
    check("frame_start", frame_start, m_t == 0);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_to(input int t);
    for (int g = 0; g <= FP && m_t != t; g++) cycle();
  endtask

  task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] en, input logic lz);
    value    = v;
    digit_en = en;
    lzs_en   = lz;
    load     = 1'b1;
    cycle();
    load     = 1'b0;
  endtask

  // Counts anode-low cycles per digit over one whole frame starting at the commit cycle.
  task automatic lit_frame(input logic [N-1:0] exp_lit);
    int cnt[N];
    for (int d = 0; d < N; d++) cnt[d] = 0;
    repeat (FP) begin
      cycle();
      for (int d = 0; d < N; d++) if (!digit_sel_n[d]) cnt[d]++;
    end
    for (int d = 0; d < N; d++)
      check($sformatf("lit_cycles[%0d]", d), cnt[d], exp_lit[d] ? RD : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4*N-1:0] v;
    int nz;

    reset_n  = 1'b0;
    load     = 1'b0;
    value    = '0;
    digit_en = '0;
    lzs_en   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_sel", digit_sel_n, 4'b1111);
    check("reset_num", num_out, 4'h0);
    check("reset_fs", frame_start, 1'b0);
    reset_n = 1'b1;

    // Idle: dark display, frame_start every FP cycles.
    run(2 * FP + 3);

    // Basic scan.
    do_load(16'h1234, 4'b1111, 1'b0);
    run_to(FP - 1);
    lit_frame(4'b1111);

    // Frame coherence: load during digit-1 SHOW.
    run_to(13);
    do_load(16'hABCD, 4'b1111, 1'b0);
    run_to(FP - 1);
    run(FP);

    // Load on the commit edge while another value is pending.
    run_to(5);
    do_load(16'h5678, 4'b1111, 1'b0);
    run_to(FP - 1);
    do_load(16'h9ABC, 4'b1111, 1'b0);
    run(2 * FP);

    // Load during the frame_start cycle is deferred a full frame.
    do_load(16'h0F0F, 4'b1111, 1'b0);
    run(2 * FP);

    // Leading-zero suppression.
    do_load(16'h0050, 4'b1111, 1'b1);
    run_to(FP - 1);
    lit_frame(4'b0011);
    do_load(16'h0000, 4'b1111, 1'b1);
    run_to(FP - 1);
    lit_frame(4'b0001);

    // Enable mask.
    do_load(16'h3C07, 4'b0101, 1'b0);
    run_to(FP - 1);
    lit_frame(4'b0101);

    // Randomized loads at random times.
    for (int k = 0; k < 40; k++) begin
      run($urandom_range(0, 60));
      v  = 16'($urandom);
      nz = $urandom_range(0, N);
      for (int i = N - nz; i < N; i++) v[4*i +: 4] = 4'h0;
      do_load(v, 4'($urandom), 1'($urandom));
    end
    run(2 * FP);

    // Asynchronous reset during digit-2 SHOW.
    do_load(16'h1234, 4'b1111, 1'b0);
    run_to(FP - 1);
    run_to(24);
    check("pre_reset_sel", digit_sel_n, 4'b1011);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_sel", digit_sel_n, 4'b1111);
    check("async_reset_num", num_out, 4'h0);
    check("async_reset_fs", frame_start, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_to(FP - 1);
    lit_frame(4'b0000);
    run(FP + 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one registered hex decoder, `seven_seg_display`.
- Drives the decoder's 4-bit `num` input and the per-digit anode enables.
- Inserts blanking gaps between digits to prevent ghosting.
- Applies new display values only at frame boundaries, so a frame never shows a mix of old and new values.
- Sits between the CPU debug/register-display path and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 2..8.
- REFRESH_DIV, 50000: length of each digit's lit (SHOW) phase, in clk cycles; must be >=1.
- BLANK_CYCLES, 16: all-anodes-off gap before each digit, in clk cycles; must be >=2 to cover the decoder's 1-cycle latency.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- load, input, 1: one-cycle strobe that captures `value`, `digit_en` and `lzs_en` into the shadow registers.
- value, input, 4*NUM_DIGITS: one hex nibble per digit; nibble i drives digit i; digit 0 is the least significant.
- digit_en, input, NUM_DIGITS: per-digit enable; 0 keeps that digit dark.
- lzs_en, input, 1: enables leading-zero suppression.
- num_out, output, 4: nibble sent to the decoder's `num` input.
- digit_sel_n, output, NUM_DIGITS: anode enables, active-low; at most one bit is low at any time.
- frame_start, output, 1: one-cycle pulse when a new frame begins, i.e. on the commit cycle.

Behaviour:
- Reset state (asynchronous, takes effect as soon as reset_n falls):
  - digit_sel_n all 1s; num_out = 0; frame_start = 0.
  - Digit index = 0; FSM state = BLANK; blank counter = 0; prescaler = 0.
  - Shadow and frame registers = 0 (value 0, enables 0, lzs 0); pending flag = 0.
- Shadow and commit:
  - On load, shadow <= {value, digit_en, lzs_en} and pending <= 1.
  - Back-to-back loads: the last one wins.
  - Commit happens on entry to BLANK with index 0. If pending, frame <= shadow and pending <= 0. frame_start pulses on every such entry.
  - A load in the same cycle as a commit lands in the shadow and is applied at the next commit; pending stays 1.
- FSM, two states:
  - BLANK: digit_sel_n all 1s. num_out = frame nibble[idx], registered on BLANK entry. Stay for BLANK_CYCLES cycles, then go to SHOW.
  - SHOW: digit_sel_n[idx] = 0 unless idx is dark; other bits 1. Stay for REFRESH_DIV cycles. Then idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1 and go to BLANK.
  - The first BLANK after reset release is the idx-0 entry: commit check runs and frame_start pulses.
- Dark digit rule: digit i is dark if frame digit_en[i] = 0, or if it is suppressed. Dark digits still consume their full BLANK+SHOW slot, so scan timing is fixed.
- Leading-zero suppression: digit i is suppressed when frame lzs = 1, i != 0, and frame nibbles NUM_DIGITS-1 down to i are all zero. Digit 0 is never suppressed.
- Timing:
  - Frame period = NUM_DIGITS*(REFRESH_DIV + BLANK_CYCLES) cycles.
  - Each enabled digit's anode is low for exactly REFRESH_DIV consecutive cycles per frame.
  - num_out is stable for the whole of BLANK and SHOW. Because BLANK_CYCLES >= 2, decoder segments are settled before the anode asserts.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Counter widths are sized by $clog2 of the parameters. Counters wrap only under the explicit FSM transitions.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; frame period = 40 cycles):
- Reset/idle: hold reset_n low, then release with no load → digit_sel_n = 4'b1111 and num_out = 0 throughout; frame_start pulses every 40 cycles, starting at the first cycle after release.
- Basic scan: load value = 16'h1234, digit_en = 4'b1111, lzs_en = 0 → after the next frame_start, the sequence is:
  - 2 cycles 1111, then 8 cycles 1110 with num_out = 4;
  - 2 cycles 1111, then 8 cycles 1101 with num_out = 3;
  - likewise 1011 with 2 and 0111 with 1;
  - the sequence repeats with a 40-cycle period.
- Frame coherence: with 16'h1234 displayed, load 16'hABCD during the digit-1 SHOW → digits 2 and 3 of the current frame still show 2 and 1; num_out = D/C/B/A from the next frame_start. A load in the frame_start cycle is deferred by one full frame.
- Leading-zero suppression: lzs_en = 1, value = 16'h0050 → digits 3 and 2 never asserted; digit 1 shows 5 and digit 0 shows 0. With value = 16'h0000, only digit 0 is lit, showing 0.
- Enable mask: digit_en = 4'b0101 → only digit_sel_n bits 0 and 2 ever go low; slot timing is unchanged (40-cycle frame).
- Reset mid-SHOW: assert reset_n low asynchronously during digit-2 SHOW → digit_sel_n = 1111 before the next clk edge. After release, the scan restarts at idx 0 and the display stays dark until a new load is committed.
